exception_sequencer: RTL and testbench

- Parametrised multicycle sequencer that takes over datapath control when one of N_CAUSES exception requests is accepted.
- Sequence: save PC-4 into EPC, read the handler vector byte from memory (latency configurable), load it into PC, then hand control back to the main control FSM.
- Sits beside the main control unit. Its outputs are OR-ed into the datapath mux and write-enable lines while Busy=1.
- Generalises the fixed three-cause exception path: cause count, memory wait latency and vector base are parameters, with priority arbitration and pending-request capture.

---
 rtl/exception_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_exception_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_sequencer.sv
// Multicycle exception entry sequencer: saves PC-4 into EPC, fetches the handler
// vector byte, loads it into PC, then returns datapath ownership to the main FSM.
module exception_sequencer #(
    parameter int unsigned N_CAUSES    = 3,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] VECTOR_BASE = 32'h000000FD,
    localparam int unsigned CAUSE_W    = (N_CAUSES > 1) ? $clog2(N_CAUSES) : 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [N_CAUSES-1:0] Exception_Req,
    input  logic                AllowException,
    output logic                Busy,
    output logic                Done,
    output logic [CAUSE_W-1:0]  Cause,
    output logic [ADDR_W-1:0]   Vector_Addr,
    output logic                IorD_Vector,
    output logic                Mem_WR,
    output logic                ALU_SrcA,
    output logic [1:0]          ALU_SrcB,
    output logic [3:0]          ALU_Op,
    output logic                EPC_Write,
    output logic                PC_Src_Vector,
    output logic                PC_Write
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_EPC,
        ST_MEM_WAIT,
        ST_LOAD_PC,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_CAUSES-1:0] pend_q, pend_d;
    logic [CAUSE_W-1:0]  cause_q, cause_d;
    logic [ADDR_W-1:0]   vaddr_q, vaddr_d;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       iord_q, iord_d;
    logic [1:0] srcb_q, srcb_d;
    logic [3:0] aluop_q, aluop_d;
    logic       epcw_q, epcw_d;
    logic       pcsrc_q, pcsrc_d;
    logic       pcw_q, pcw_d;

    logic [N_CAUSES-1:0] eff;
    logic [CAUSE_W-1:0]  win_idx;
    logic                win_found;

    assign eff = Exception_Req | pend_q;

    // Fixed priority: lowest set index of the effective request vector.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < int'(N_CAUSES); i++) begin
            if (eff[i] && !win_found) begin
                win_idx   = CAUSE_W'(i);
                win_found = 1'b1;
            end
        end
    end

    // Next-state, counter, pending and cause update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q | Exception_Req;
        cause_d = cause_q;
        unique case (state_q)
            ST_IDLE: begin
                if (AllowException && win_found) begin
                    cause_d = win_idx;
                    pend_d  = eff & ~(N_CAUSES'(1) << win_idx);
                    state_d = ST_SAVE_EPC;
                end
            end
            ST_SAVE_EPC: begin
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_LOAD_PC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LOAD_PC: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Moore decode of the upcoming state so the output flops track the state register.
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        iord_d  = 1'b0;
        srcb_d  = 2'b00;
        aluop_d = 4'b0000;
        epcw_d  = 1'b0;
        pcsrc_d = 1'b0;
        pcw_d   = 1'b0;
        vaddr_d = ADDR_W'(VECTOR_BASE) + ADDR_W'(cause_d);
        unique case (state_d)
            ST_SAVE_EPC: begin
                busy_d  = 1'b1;
                srcb_d  = 2'b01;
                aluop_d = 4'b0010;
                epcw_d  = 1'b1;
            end
            ST_MEM_WAIT: begin
                busy_d = 1'b1;
                iord_d = 1'b1;
            end
            ST_LOAD_PC: begin
                busy_d  = 1'b1;
                iord_d  = 1'b1;
                pcsrc_d = 1'b1;
                pcw_d   = 1'b1;
            end
            ST_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            cause_q <= '0;
            vaddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            iord_q  <= 1'b0;
            srcb_q  <= 2'b00;
            aluop_q <= 4'b0000;
            epcw_q  <= 1'b0;
            pcsrc_q <= 1'b0;
            pcw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            cause_q <= cause_d;
            vaddr_q <= vaddr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            iord_q  <= iord_d;
            srcb_q  <= srcb_d;
            aluop_q <= aluop_d;
            epcw_q  <= epcw_d;
            pcsrc_q <= pcsrc_d;
            pcw_q   <= pcw_d;
        end
    end

    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Cause         = cause_q;
    assign Vector_Addr   = vaddr_q;
    assign IorD_Vector   = iord_q;
    assign Mem_WR        = 1'b0;
    assign ALU_SrcA      = 1'b0;
    assign ALU_SrcB      = srcb_q;
    assign ALU_Op        = aluop_q;
    assign EPC_Write     = epcw_q;
    assign PC_Src_Vector = pcsrc_q;
    assign PC_Write      = pcw_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Scoreboard bench for exception_sequencer: directed entries with expected
// cause/vector/latency queued by stimulus and checked by a Done-driven monitor.
module tb_exception_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  req   = 3'b000;
    logic        allow = 1'b0;

    logic        Busy, Done, IorD_Vector, Mem_WR, ALU_SrcA, EPC_Write, PC_Src_Vector, PC_Write;
    logic [1:0]  Cause, ALU_SrcB;
    logic [3:0]  ALU_Op;
    logic [31:0] Vector_Addr;

    // Secondary latency-only instances (WAIT_CYCLES = 1 and 5)
    logic [2:0]  rx = 3'b000;
    logic        ax = 1'b0;
    logic        a_busy, a_done, a_iord, a_memwr, a_srca, a_epc, a_pcsrc, a_pcw;
    logic [1:0]  a_cause, a_srcb;
    logic [3:0]  a_op;
    logic [31:0] a_vaddr;
    logic        b_busy, b_done, b_iord, b_memwr, b_srca, b_epc, b_pcsrc, b_pcw;
    logic [1:0]  b_cause, b_srcb;
    logic [3:0]  b_op;
    logic [31:0] b_vaddr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cause;
        logic [31:0] vaddr;
        int          lat;
        int          gap;
    } exp_t;
    exp_t q[$];

    exception_sequencer #(.WAIT_CYCLES(2)) dut (
        .Clock(Clock), .Reset(Reset), .Exception_Req(req), .AllowException(allow),
        .Busy(Busy), .Done(Done), .Cause(Cause), .Vector_Addr(Vector_Addr),
        .IorD_Vector(IorD_Vector), .Mem_WR(Mem_WR), .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB),
        .ALU_Op(ALU_Op), .EPC_Write(EPC_Write), .PC_Src_Vector(PC_Src_Vector), .PC_Write(PC_Write)
    );

    exception_sequencer #(.WAIT_CYCLES(1)) dut_w1 (
        .Clock(Clock), .Reset(Reset), .Exception_Req(rx), .AllowException(ax),
        .Busy(a_busy), .Done(a_done), .Cause(a_cause), .Vector_Addr(a_vaddr),
        .IorD_Vector(a_iord), .Mem_WR(a_memwr), .ALU_SrcA(a_srca), .ALU_SrcB(a_srcb),
        .ALU_Op(a_op), .EPC_Write(a_epc), .PC_Src_Vector(a_pcsrc), .PC_Write(a_pcw)
    );

    exception_sequencer #(.WAIT_CYCLES(5)) dut_w5 (
        .Clock(Clock), .Reset(Reset), .Exception_Req(rx), .AllowException(ax),
        .Busy(b_busy), .Done(b_done), .Cause(b_cause), .Vector_Addr(b_vaddr),
        .IorD_Vector(b_iord), .Mem_WR(b_memwr), .ALU_SrcA(b_srca), .ALU_SrcB(b_srcb),
        .ALU_Op(b_op), .EPC_Write(b_epc), .PC_Src_Vector(b_pcsrc), .PC_Write(b_pcw)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input int cause, input logic [31:0] vaddr, input int gap);
        exp_t e;
        e.cause = cause;
        e.vaddr = vaddr;
        e.lat   = 5;
        e.gap   = gap;
        q.push_back(e);
    endtask

    task automatic drain(input int max_cycles);
        for (int n = 0; n < max_cycles; n++) begin
            if (q.size() == 0 && !Busy) break;
            tick();
        end
        check("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({Busy, Done, Cause, Vector_Addr, IorD_Vector, Mem_WR, ALU_SrcA,
                    ALU_SrcB, ALU_Op, EPC_Write, PC_Src_Vector, PC_Write});
    endfunction

    // Main-instance monitor: per-sequence strobe counts, checked when Done appears
    int epc_cyc = 0, last_done = -100;
    int n_epc = 0, n_iord = 0, n_pcw = 0;
    bit bad_vaddr = 0, bad_ctl = 0;
    always @(negedge Clock) begin
        if (Reset) begin
            n_epc = 0; n_iord = 0; n_pcw = 0; bad_vaddr = 0; bad_ctl = 0;
        end else begin
            if (Mem_WR !== 1'b0) bad_ctl = 1;
            if (!Busy && (EPC_Write || PC_Write || IorD_Vector || Done)) bad_ctl = 1;
            if (EPC_Write) begin
                n_epc++;
                epc_cyc = cyc;
                if (ALU_SrcA !== 1'b0 || ALU_SrcB !== 2'b01 || ALU_Op !== 4'b0010) bad_ctl = 1;
                if (q.size() > 0 && q[0].gap != 0)
                    check("reentry_gap", 64'(cyc - last_done), 64'(q[0].gap));
            end else if (Busy && ALU_Op !== 4'b0000) begin
                bad_ctl = 1;
            end
            if (IorD_Vector) begin
                n_iord++;
                if (q.size() > 0 && Vector_Addr !== q[0].vaddr) bad_vaddr = 1;
            end
            if (PC_Write) begin
                n_pcw++;
                if (!PC_Src_Vector) bad_ctl = 1;
            end
            if (Done) begin
                if (q.size() == 0) begin
                    check("unexpected_done_cause", 64'(Cause), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_cause", 64'(Cause), 64'(e.cause));
                    check("done_latency", 64'(cyc - epc_cyc + 1), 64'(e.lat));
                    check("epc_write_cycles", 64'(n_epc), 64'd1);
                    check("iord_cycles", 64'(n_iord), 64'd3);
                    check("pc_write_cycles", 64'(n_pcw), 64'd1);
                    check("vector_addr_ok", 64'(bad_vaddr), 64'd0);
                    check("control_lines_ok", 64'(bad_ctl), 64'd0);
                end
                last_done = cyc;
                n_epc = 0; n_iord = 0; n_pcw = 0; bad_vaddr = 0; bad_ctl = 0;
            end
        end
    end

    // Latency monitors for the WAIT_CYCLES=1 and WAIT_CYCLES=5 instances
    int a_epc_cyc = 0, b_epc_cyc = 0, a_seen = 0, b_seen = 0;
    always @(negedge Clock) begin
        if (!Reset) begin
            if (a_epc) a_epc_cyc = cyc;
            if (b_epc) b_epc_cyc = cyc;
            if (a_done) begin
                check("w1_latency", 64'(cyc - a_epc_cyc + 1), 64'd4);
                check("w1_cause", 64'(a_cause), 64'd2);
                a_seen++;
            end
            if (b_done) begin
                check("w5_latency", 64'(cyc - b_epc_cyc + 1), 64'd8);
                check("w5_vaddr", 64'(b_vaddr), 64'hFF);
                b_seen++;
            end
        end
    end

    initial begin
        // Reset state
        Reset = 1'b1;
        tick();
        tick();
        check("reset_outputs", all_outs(), 64'd0);
        Reset = 1'b0;
        tick();

        // Single request, cause 1
        allow = 1'b1;
        req   = 3'b010;
        push(1, 32'hFE, 0);
        tick();
        req = 3'b000;
        drain(40);
        check("cause_held_after_done", 64'(Cause), 64'd1);

        // Simultaneous 1 and 2: cause 1 first, cause 2 from Pending after one IDLE cycle
        req = 3'b110;
        push(1, 32'hFE, 0);
        push(2, 32'hFF, 2);
        tick();
        req = 3'b000;
        drain(60);

        // Cause 0 pulsed during MEM_WAIT of a cause-2 sequence
        req = 3'b100;
        push(2, 32'hFF, 0);
        push(0, 32'hFD, 2);
        tick();
        req = 3'b000;
        tick();
        req = 3'b001;
        tick();
        req = 3'b000;
        drain(60);

        // Masked request accumulates while AllowException=0
        allow = 1'b0;
        req   = 3'b100;
        for (int i = 0; i < 4; i++) begin
            check("masked_busy_low", 64'(Busy), 64'd0);
            tick();
            req = 3'b000;
        end
        check("masked_busy_low_end", 64'(Busy), 64'd0);
        allow = 1'b1;
        push(2, 32'hFF, 0);
        tick();
        check("masked_accept_epc", 64'(EPC_Write), 64'd1);
        drain(40);

        // Reset during MEM_WAIT with a captured pending request
        req = 3'b010;
        tick();
        req = 3'b001;
        tick();
        req = 3'b000;
        check("pre_abort_in_mem_wait", 64'(IorD_Vector), 64'd1);
        Reset = 1'b1;
        tick();
        check("abort_outputs_zero", all_outs(), 64'd0);
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_abort_busy", 64'({Busy, PC_Write}), 64'd0);
        end

        // Latency of WAIT_CYCLES=1 and WAIT_CYCLES=5 builds
        ax = 1'b1;
        rx = 3'b100;
        tick();
        rx = 3'b000;
        for (int i = 0; i < 30; i++) begin
            if (a_seen != 0 && b_seen != 0) break;
            tick();
        end
        check("alt_builds_done_count", 64'(a_seen + b_seen), 64'd2);

        tick();
        check("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
